// File: rtl/kernel_seq_ctrl.sv
// kernel_seq_ctrl: issue/drain sequencer for the c[i] = (a+2b)*(a+5b) kernel datapath.
// Optional busy-cycle counter enabled by defining KSEQ_PERF_CNT_EN.
`default_nettype none

module kernel_seq_ctrl #(
   parameter int AW      = 8,
   parameter int MEM_LAT = 1,
   parameter int DP_LAT  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [31:0]   n,
   input  logic          hold,
   output logic          busy,
   output logic          done,
   output logic          ovf,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          dp_valid,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [31:0]   cycles
);

   localparam int          TOT     = MEM_LAT + DP_LAT;
   localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
   localparam logic [32:0] DEPTH_W = 33'(1) << AW;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   idx_q, idx_d;
   logic [AW:0]   wr_cnt_q, wr_cnt_d;
   logic          ovf_q, ovf_d;
   logic [TOT-1:0] vld_q;
   logic [AW-1:0] addr_q [TOT];

   logic          n_ovf_w;
   logic [AW:0]   n_cnt_w;

   assign n_ovf_w = ({1'b0, n} > DEPTH_W);
   assign n_cnt_w = n_ovf_w ? DEPTH_C : n[AW:0];

   assign rd_en    = (state_q == S_ISSUE) && !hold;
   assign rd_addr  = rd_en ? idx_q[AW-1:0] : '0;
   assign dp_valid = vld_q[MEM_LAT-1];
   assign wr_en    = vld_q[TOT-1];
   assign wr_addr  = addr_q[TOT-1];
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign ovf      = ovf_q;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      idx_d    = idx_q;
      ovf_d    = ovf_q;
      wr_cnt_d = wr_en ? wr_cnt_q + (AW+1)'(1) : wr_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               count_d  = n_cnt_w;
               ovf_d    = n_ovf_w;
               idx_d    = '0;
               wr_cnt_d = '0;
               state_d  = (n_cnt_w == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (rd_en) begin
               idx_d = idx_q + (AW+1)'(1);
               if (idx_q == count_q - (AW+1)'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Leave on the edge that samples the last write strobe.
            if (wr_en && (wr_cnt_q + (AW+1)'(1) == count_q)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         idx_q    <= '0;
         wr_cnt_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         wr_cnt_q <= wr_cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Valid and address travel together through memory + datapath latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < TOT; i++) addr_q[i] <= '0;
      end else begin
         vld_q     <= {vld_q[TOT-2:0], rd_en};
         addr_q[0] <= rd_addr;
         for (int i = 1; i < TOT; i++) addr_q[i] <= addr_q[i-1];
      end
   end

`ifdef KSEQ_PERF_CNT_EN
   logic [31:0] cyc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q <= '0;
      end else if ((state_q == S_IDLE) && start) begin
         cyc_q <= '0;
      end else if (busy) begin
         cyc_q <= cyc_q + 32'd1;
      end
   end

   assign cycles = cyc_q;
`else
   assign cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kernel_seq_ctrl.sv
// Directed self-checking bench for kernel_seq_ctrl (default AW=8 instance plus an AW=2 instance).
`default_nettype none

module tb_kernel_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] n;
   logic        hold;

   logic        a_busy, a_done, a_ovf, a_rd_en, a_dp_valid, a_wr_en;
   logic [7:0]  a_rd_addr, a_wr_addr;
   logic [31:0] a_cycles;
   logic        b_busy, b_done, b_ovf, b_rd_en, b_dp_valid, b_wr_en;
   logic [1:0]  b_rd_addr, b_wr_addr;
   logic [31:0] b_cycles;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] h_rd, h_dp, h_wr, h_done, h_busy;
   logic [31:0] rd_addrs, wr_addrs;

   always #5 clk = ~clk;

   kernel_seq_ctrl #(.AW(8), .MEM_LAT(1), .DP_LAT(2)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .n(n), .hold(hold),
      .busy(a_busy), .done(a_done), .ovf(a_ovf), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
      .dp_valid(a_dp_valid), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .cycles(a_cycles)
   );

   kernel_seq_ctrl #(.AW(2), .MEM_LAT(1), .DP_LAT(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .n(n), .hold(hold),
      .busy(b_busy), .done(b_done), .ovf(b_ovf), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
      .dp_valid(b_dp_valid), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .cycles(b_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives start so that it is sampled at the next edge (E0).
   task automatic begin_run(input logic [31:0] nn);
      n     = nn;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Bit k of each history holds the value sampled at edge Ek.
   task automatic capture(input bit selb, input int len,
                          input logic [15:0] hold_pat, input logic [15:0] start_pat);
      logic s_rd, s_dp, s_wr, s_done, s_busy;
      logic [7:0] s_ra, s_wa;
      h_rd = '0; h_dp = '0; h_wr = '0; h_done = '0; h_busy = '0;
      rd_addrs = '0; wr_addrs = '0;
      for (int k = 1; k <= len; k++) begin
         hold  = hold_pat[k];
         start = start_pat[k];
         #1;
         s_rd   = selb ? b_rd_en    : a_rd_en;
         s_dp   = selb ? b_dp_valid : a_dp_valid;
         s_wr   = selb ? b_wr_en    : a_wr_en;
         s_done = selb ? b_done     : a_done;
         s_busy = selb ? b_busy     : a_busy;
         s_ra   = selb ? {6'd0, b_rd_addr} : a_rd_addr;
         s_wa   = selb ? {6'd0, b_wr_addr} : a_wr_addr;
         h_rd[k] = s_rd; h_dp[k] = s_dp; h_wr[k] = s_wr;
         h_done[k] = s_done; h_busy[k] = s_busy;
         if (s_rd) rd_addrs = {rd_addrs[23:0], s_ra};
         if (s_wr) wr_addrs = {wr_addrs[23:0], s_wa};
         @(posedge clk); #1;
      end
      hold  = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_cyc8, exp_cyc10, exp_cyc1;
`ifdef KSEQ_PERF_CNT_EN
      exp_cyc8 = 32'd8; exp_cyc10 = 32'd10; exp_cyc1 = 32'd1;
`else
      exp_cyc8 = 32'd0; exp_cyc10 = 32'd0; exp_cyc1 = 32'd0;
`endif
      rst = 1'b0; start = 1'b0; n = '0; hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {a_busy, a_done, a_ovf, a_rd_en, a_dp_valid, a_wr_en, a_wr_addr}, '0);
      chk("reset_cycles", a_cycles, '0);
      #2 rst = 1'b1;
      @(posedge clk); #1;

      // Basic run n=4
      begin_run(4);
      capture(1'b0, 10, 16'h0, 16'h0);
      chk("basic_rd", 32'(h_rd), 32'h001E);
      chk("basic_dp", 32'(h_dp), 32'h003C);
      chk("basic_wr", 32'(h_wr), 32'h00F0);
      chk("basic_done", 32'(h_done), 32'h0100);
      chk("basic_busy", 32'(h_busy), 32'h01FE);
      chk("basic_rdaddr", rd_addrs, 32'h00010203);
      chk("basic_wraddr", wr_addrs, 32'h00010203);
      chk("basic_cycles", a_cycles, exp_cyc8);

      // Zero count
      begin_run(0);
      capture(1'b0, 3, 16'h0, 16'h0);
      chk("zero_rdwr", 32'(h_rd | h_wr), 32'h0);
      chk("zero_done", 32'(h_done), 32'h0002);
      chk("zero_busy", 32'(h_busy), 32'h0002);
      chk("zero_cycles", a_cycles, exp_cyc1);

      // Hold for two cycles after the second issue
      begin_run(4);
      capture(1'b0, 11, 16'h0018, 16'h0);
      chk("hold_rd", 32'(h_rd), 32'h0066);
      chk("hold_dp", 32'(h_dp), 32'h00CC);
      chk("hold_wr", 32'(h_wr), 32'h0330);
      chk("hold_done", 32'(h_done), 32'h0400);
      chk("hold_rdaddr", rd_addrs, 32'h00010203);
      chk("hold_wraddr", wr_addrs, 32'h00010203);
      chk("hold_cycles", a_cycles, exp_cyc10);

      // Overflow on the AW=2 instance
      begin_run(7);
      capture(1'b1, 10, 16'h0, 16'h0);
      chk("ovf_rd", 32'(h_rd), 32'h001E);
      chk("ovf_rdaddr", rd_addrs, 32'h00010203);
      chk("ovf_wr", 32'(h_wr), 32'h00F0);
      chk("ovf_done", 32'(h_done), 32'h0100);
      chk("ovf_flag", 32'(b_ovf), 32'h1);
      repeat (4) @(posedge clk);
      #1;
      chk("ovf_sticky", 32'(b_ovf), 32'h1);
      chk("ovf_wide_clear", 32'(a_ovf), 32'h0);
      begin_run(2);
      chk("ovf_cleared", 32'(b_ovf), 32'h0);
      capture(1'b1, 8, 16'h0, 16'h0);
      chk("n2_rd", 32'(h_rd), 32'h0006);
      chk("n2_wr", 32'(h_wr), 32'h0030);
      chk("n2_done", 32'(h_done), 32'h0040);

      // Start while busy is ignored
      begin_run(4);
      n = 32'd9;
      capture(1'b0, 12, 16'h0, 16'h0004);
      chk("busy_start_rd", 32'(h_rd), 32'h001E);
      chk("busy_start_wr", 32'(h_wr), 32'h00F0);
      chk("busy_start_done", 32'(h_done), 32'h0100);

      // Reset during DRAIN
      begin_run(8);
      capture(1'b0, 9, 16'h0, 16'h0);
      chk("pre_rst_wr", 32'(a_wr_en), 32'h1);
      rst = 1'b0;
      #1;
      chk("rst_outs", {a_busy, a_done, a_ovf, a_rd_en, a_dp_valid, a_wr_en, a_wr_addr, a_rd_addr}, '0);
      chk("rst_cycles", a_cycles, '0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      capture(1'b0, 6, 16'h0, 16'h0);
      chk("post_rst_wr", 32'(h_wr | h_busy), 32'h0);
      begin_run(4);
      capture(1'b0, 10, 16'h0, 16'h0);
      chk("rerun_wr", 32'(h_wr), 32'h00F0);
      chk("rerun_wraddr", wr_addrs, 32'h00010203);
      chk("rerun_done", 32'(h_done), 32'h0100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
